// File: rtl/onehot_scan_pkg.sv
// Shared types and constants for the one-hot scan decoder and its display logic.
package onehot_scan_pkg;

    // Operating state of the decoder.
    typedef enum logic [1:0] {
        ST_OFF,
        ST_DIRECT,
        ST_SCAN
    } scan_state_e;

    // Active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_D0    = 7'b1000000;
    localparam logic [6:0] SEG_D1    = 7'b1111001;
    localparam logic [6:0] SEG_D2    = 7'b0100100;
    localparam logic [6:0] SEG_D3    = 7'b0110000;
    localparam logic [6:0] SEG_D4    = 7'b0011001;
    localparam logic [6:0] SEG_D5    = 7'b0010010;
    localparam logic [6:0] SEG_D6    = 7'b0000010;
    localparam logic [6:0] SEG_D7    = 7'b1111000;

    // Segment pattern for an octal digit.
    function automatic logic [6:0] seg_lookup(input logic [2:0] digit);
        logic [6:0] pat;
        unique case (digit)
            3'd0:    pat = SEG_D0;
            3'd1:    pat = SEG_D1;
            3'd2:    pat = SEG_D2;
            3'd3:    pat = SEG_D3;
            3'd4:    pat = SEG_D4;
            3'd5:    pat = SEG_D5;
            3'd6:    pat = SEG_D6;
            default: pat = SEG_D7;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational octal digit to active-low seven-segment decoder with blanking.
module seg7_dec
    import onehot_scan_pkg::*;
(
    input  logic [2:0] digit,
    input  logic       valid,
    output logic [6:0] seg
);

    // Blank the display whenever the code is not valid.
    always_comb begin
        seg = valid ? seg_lookup(digit) : SEG_BLANK;
    end

endmodule

// File: rtl/onehot_scan_dec.sv
// Registered inverse of the 8-input priority encoder with an auto-scan LED walker.
// Outputs are decoded purely from the registered code {k_r, y_r}.
module onehot_scan_dec
    import onehot_scan_pkg::*;
#(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       mode,
    input  logic       dir,
    input  logic       hold,
    input  logic       k_in,
    input  logic [2:0] y_in,
    output logic [7:0] led,
    output logic [6:0] seg,
    output logic [2:0] idx,
    output logic       k_out,
    output logic       tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    scan_state_e   st, st_nxt;
    logic          k_r, k_nxt;
    logic [2:0]    y_r, y_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tick_r, tick_nxt;

    // State, code and prescaler registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st     <= ST_OFF;
            k_r    <= 1'b0;
            y_r    <= 3'd0;
            cnt    <= '0;
            tick_r <= 1'b0;
        end else begin
            st     <= st_nxt;
            k_r    <= k_nxt;
            y_r    <= y_nxt;
            cnt    <= cnt_nxt;
            tick_r <= tick_nxt;
        end
    end

    // Next-state, next-code and scan stepping; the destination state decides,
    // so leaving SCAN at terminal count never steps.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        st_nxt   = en ? (mode ? ST_SCAN : ST_DIRECT) : ST_OFF;
        k_nxt    = k_r;
        y_nxt    = y_r;
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;

        unique case (st_nxt)
            ST_OFF: begin
                k_nxt   = 1'b0;
                cnt_nxt = '0;
            end
            ST_DIRECT: begin
                k_nxt   = k_in;
                y_nxt   = y_in;
                cnt_nxt = '0;
            end
            default: begin
                if (st != ST_SCAN) begin
                    // Entry edge: seed the position, no step yet.
                    k_nxt   = 1'b1;
                    cnt_nxt = '0;
                    y_nxt   = k_in ? y_in : 3'd1;
                end else if (!hold) begin
                    if (cnt == CNT_MAX) begin
                        cnt_nxt  = '0;
                        y_nxt    = dir ? (y_r - 3'd1) : (y_r + 3'd1);
                        tick_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    // One-hot LED decode: y=0 lights bit 7, y=n lights bit n-1.
    always_comb begin
        logic [2:0] led_bit;
        led_bit = y_r - 3'd1;
        led     = k_r ? (8'd1 << led_bit) : 8'd0;
    end

    seg7_dec u_seg7_dec (
        .digit (y_r),
        .valid (k_r),
        .seg   (seg)
    );

    assign idx   = y_r;
    assign k_out = k_r;
    assign tick  = tick_r;

endmodule

// File: tb/tb_onehot_scan_dec.sv
// Scoreboard bench for onehot_scan_dec: the stimulus process drives inputs and
// queues the reference response; a monitor pops and compares after each edge.
module tb_onehot_scan_dec;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, dir, hold, k_in;
    logic [2:0] y_in;
    logic [7:0] led;
    logic [6:0] seg;
    logic [2:0] idx;
    logic       k_out, tick;

    onehot_scan_dec #(.DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .dir   (dir),
        .hold  (hold),
        .k_in  (k_in),
        .y_in  (y_in),
        .led   (led),
        .seg   (seg),
        .idx   (idx),
        .k_out (k_out),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] led;
        logic [6:0] seg;
        logic [2:0] idx;
        logic       k;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [6:0] seg_tbl [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    // Reference model: mode name, displayed code, and non-held scan edges since entry.
    int m_st;   // 0 off, 1 direct, 2 scan
    int m_k;
    int m_y;
    int m_el;
    int m_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_k = 0; m_y = 0; m_el = 0; m_tick = 0;
    endtask

    task automatic model_edge(input int e, input int md, input int d, input int h,
                              input int k, input int y);
        int nst;
        nst    = (e == 0) ? 0 : ((md != 0) ? 2 : 1);
        m_tick = 0;
        if (nst == 0) begin
            m_k = 0;
        end else if (nst == 1) begin
            m_k = k;
            m_y = y;
        end else if (m_st != 2) begin
            m_k  = 1;
            m_y  = (k != 0) ? y : 1;
            m_el = 0;
        end else if (h == 0) begin
            m_el++;
            if (m_el % DIV == 0) begin
                m_y    = (d != 0) ? (m_y + 7) % 8 : (m_y + 1) % 8;
                m_tick = 1;
            end
        end
        m_st = nst;
    endtask

    function automatic exp_t expect_now();
        exp_t x;
        x.led  = (m_k != 0) ? 8'(1 << ((m_y + 7) % 8)) : 8'h00;
        x.seg  = (m_k != 0) ? seg_tbl[m_y] : 7'h7F;
        x.idx  = 3'(m_y);
        x.k    = 1'(m_k);
        x.tick = 1'(m_tick);
        return x;
    endfunction

    // Drive one edge worth of inputs and queue the response expected after it.
    task automatic cycle(input logic e, input logic md, input logic d, input logic h,
                         input logic k, input logic [2:0] y);
        @(negedge clk);
        en = e; mode = md; dir = d; hold = h; k_in = k; y_in = y;
        model_edge(int'(e), int'(md), int'(d), int'(h), int'(k), int'(y));
        exp_q.push_back(expect_now());
    endtask

    task automatic check_now(input string tag);
        exp_t x;
        x = expect_now();
        check({tag, "_led"}, 32'(led), 32'(x.led));
        check({tag, "_seg"}, 32'(seg), 32'(x.seg));
        check({tag, "_idx"}, 32'(idx), 32'(x.idx));
        check({tag, "_k"},   32'(k_out), 32'(x.k));
        check({tag, "_tick"}, 32'(tick), 32'(x.tick));
    endtask

    // Monitor: compare DUT outputs shortly after each active edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("led",  32'(led),   32'(x.led));
                check("seg",  32'(seg),   32'(x.seg));
                check("idx",  32'(idx),   32'(x.idx));
                check("k_out", 32'(k_out), 32'(x.k));
                check("tick", 32'(tick),  32'(x.tick));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en = 0; mode = 0; dir = 0; hold = 0; k_in = 0; y_in = 3'd0;
        model_reset();

        // Reset state.
        #1;
        check("rst_led", 32'(led), 32'h00);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_k",   32'(k_out), 32'd0);
        check("rst_idx", 32'(idx), 32'd0);
        #12 rst_n = 1'b1;

        // DIRECT decode.
        cycle(1, 0, 0, 0, 1, 3'd3);
        cycle(1, 0, 0, 0, 1, 3'd0);
        cycle(1, 0, 0, 0, 0, 3'd5);
        cycle(1, 0, 0, 0, 1, 3'd7);

        // SCAN up with wrap 6 -> 7 -> 0 -> 1.
        cycle(1, 1, 0, 0, 1, 3'd6);
        repeat (12) cycle(1, 1, 0, 0, 0, 3'd0);

        // SCAN down 1 -> 0 -> 7, partial count, then hold and resume.
        repeat (10) cycle(1, 1, 1, 0, 0, 3'd0);
        repeat (10) cycle(1, 1, 1, 1, 0, 3'd0);
        repeat (6)  cycle(1, 1, 1, 0, 0, 3'd0);

        // SCAN entry with k_in=0, then disable at terminal count.
        cycle(1, 0, 0, 0, 0, 3'd2);
        cycle(1, 1, 0, 0, 0, 3'd2);
        repeat (3) cycle(1, 1, 0, 0, 0, 3'd2);
        cycle(0, 1, 0, 0, 0, 3'd2);
        repeat (2) cycle(0, 1, 0, 0, 1, 3'd4);

        // Mid-scan asynchronous reset, release straight into SCAN.
        cycle(1, 1, 0, 0, 1, 3'd5);
        repeat (5) cycle(1, 1, 0, 0, 0, 3'd0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_now("midrst");
        en = 1; mode = 1; dir = 0; hold = 0; k_in = 0; y_in = 3'd0;
        #1 rst_n = 1'b1;
        #1 check_now("release");
        model_edge(1, 1, 0, 0, 0, 0);
        exp_q.push_back(expect_now());
        repeat (DIV + 1) cycle(1, 1, 0, 0, 0, 3'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom),
                  3'($urandom));
        end

        // Let the monitor drain the queue.
        repeat (3) @(posedge clk);
        #2;
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
